// File: rtl/linea_retardo_pkg.sv
// Shared constants and sizing helper for the linea_retardo delay line.
package linea_retardo_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 3;
  localparam int TOTAL_W   = 8;

  // Bits needed to hold an occupancy count of 0..depth inclusive.
  function automatic int ocup_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/etapa_retardo.sv
// One valid+data stage of the delay line; one cycle per stage.
// stall holds the stage, flush clears it and wins over stall.
module etapa_retardo #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush_i) begin
      vld_d = 1'b0;
      dat_d = '0;
    end else if (!stall_i) begin
      vld_d = vld_i;
      // An empty stage always carries zero data.
      dat_d = vld_i ? dat_i : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/linea_retardo.sv
// DEPTH-stage delay line with stall/flush, occupancy and saturating output count.
// Latency is DEPTH non-stalled edges; stall freezes everything and drops the input word.
module linea_retardo
  import linea_retardo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       valid_out,
  output logic [WIDTH-1:0]           data_out,
  output logic [ocup_w(DEPTH)-1:0]   ocupacion,
  output logic [TOTAL_W-1:0]         total_out
);

  localparam int OW = ocup_w(DEPTH);

  logic             stg_vld_in [DEPTH];
  logic [WIDTH-1:0] stg_dat_in [DEPTH];
  logic             stg_vld    [DEPTH];
  logic [WIDTH-1:0] stg_dat    [DEPTH];

  logic               advance;
  logic               enter_vld;
  logic               leave_vld;
  logic               last_load_vld;
  logic [OW-1:0]      ocup_q, ocup_d;
  logic [TOTAL_W-1:0] total_q, total_d;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_first
        assign stg_vld_in[k] = valid_in;
        assign stg_dat_in[k] = data_in;
      end else begin : g_next
        assign stg_vld_in[k] = stg_vld[k-1];
        assign stg_dat_in[k] = stg_dat[k-1];
      end

      etapa_retardo #(
        .WIDTH (WIDTH)
      ) u_etapa (
        .clk     (clk),
        .reset_L (reset_L),
        .stall_i (stall),
        .flush_i (flush),
        .vld_i   (stg_vld_in[k]),
        .dat_i   (stg_dat_in[k]),
        .vld_o   (stg_vld[k]),
        .dat_o   (stg_dat[k])
      );
    end
  endgenerate

  assign advance       = !stall && !flush;
  assign enter_vld     = valid_in;
  assign leave_vld     = stg_vld[DEPTH-1];
  assign last_load_vld = stg_vld_in[DEPTH-1];

  // Occupancy tracks the valid bit entering stage 0 against the one leaving the last stage.
  always_comb begin
    ocup_d = ocup_q;
    if (flush) begin
      ocup_d = '0;
    end else if (advance) begin
      if (enter_vld && !leave_vld) begin
        ocup_d = ocup_q + OW'(1);
      end else if (!enter_vld && leave_vld) begin
        ocup_d = ocup_q - OW'(1);
      end
    end
  end

  always_comb begin
    total_d = total_q;
    if (advance && last_load_vld && (total_q != {TOTAL_W{1'b1}})) begin
      total_d = total_q + TOTAL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ocup_q  <= '0;
      total_q <= '0;
    end else begin
      ocup_q  <= ocup_d;
      total_q <= total_d;
    end
  end

  assign valid_out = stg_vld[DEPTH-1];
  assign data_out  = stg_dat[DEPTH-1];
  assign ocupacion = ocup_q;
  assign total_out = total_q;

endmodule

// File: tb/tb_linea_retardo.sv
// Directed bench for linea_retardo: default 4x3 instance plus a 16x8 instance.
module tb_linea_retardo;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;

  logic       va = 1'b0, sa = 1'b0, fa = 1'b0;
  logic [3:0] da = '0;
  logic       a_vout;
  logic [3:0] a_dout;
  logic [1:0] a_occ;
  logic [7:0] a_tot;

  logic        vb = 1'b0, sb = 1'b0, fb = 1'b0;
  logic [15:0] db = '0;
  logic        b_vout;
  logic [15:0] b_dout;
  logic [3:0]  b_occ;
  logic [7:0]  b_tot;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  linea_retardo #(.WIDTH(4), .DEPTH(3)) dut_a (
    .clk(clk), .reset_L(reset_L), .valid_in(va), .data_in(da),
    .stall(sa), .flush(fa), .valid_out(a_vout), .data_out(a_dout),
    .ocupacion(a_occ), .total_out(a_tot)
  );

  linea_retardo #(.WIDTH(16), .DEPTH(8)) dut_b (
    .clk(clk), .reset_L(reset_L), .valid_in(vb), .data_in(db),
    .stall(sb), .flush(fb), .valid_out(b_vout), .data_out(b_dout),
    .ocupacion(b_occ), .total_out(b_tot)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    va = 1'b0; da = '0; sa = 1'b0; fa = 1'b0;
    vb = 1'b0; db = '0; sb = 1'b0; fb = 1'b0;
    @(negedge clk);
    reset_L = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  // Apply one edge of stimulus to dut_a and compare its four outputs.
  task automatic run_vec(input string tag, input logic v, input logic [3:0] d,
                         input logic s, input logic f, input logic ev,
                         input logic [3:0] ed, input int eocc, input int etot);
    va = v; da = d; sa = s; fa = f;
    tick();
    check({tag, "_vld"}, a_vout, ev);
    check({tag, "_dat"}, a_dout, ed);
    check({tag, "_occ"}, a_occ, eocc);
    check({tag, "_tot"}, a_tot, etot);
  endtask

  initial begin
    int occ1 [8] = '{1, 2, 3, 3, 3, 2, 1, 0};

    #2;
    check("rst_vld", a_vout, 0);
    check("rst_dat", a_dout, 0);
    check("rst_occ", a_occ, 0);
    check("rst_tot", a_tot, 0);
    check("rst_b_vld", b_vout, 0);
    check("rst_b_tot", b_tot, 0);
    @(negedge clk);
    reset_L = 1'b1;

    // Five back-to-back words, latency three edges.
    for (int c = 1; c <= 8; c++) begin
      va = (c <= 5);
      da = (c <= 5) ? 4'(c) : 4'h0;
      tick();
      check("t1_vld", a_vout, (c >= 3 && c <= 7) ? 1 : 0);
      check("t1_dat", a_dout, (c >= 3 && c <= 7) ? c - 2 : 0);
      check("t1_occ", a_occ, occ1[c-1]);
      check("t1_tot", a_tot, (c < 3) ? 0 : ((c <= 7) ? c - 2 : 5));
    end

    // Stall for two edges while A,B are in flight; the stalled input 7 is dropped.
    do_reset();
    run_vec("t2_e1", 1, 4'hA, 0, 0, 0, 4'h0, 1, 0);
    run_vec("t2_e2", 1, 4'hB, 0, 0, 0, 4'h0, 2, 0);
    run_vec("t2_e3", 1, 4'h7, 1, 0, 0, 4'h0, 2, 0);
    run_vec("t2_e4", 1, 4'h7, 1, 0, 0, 4'h0, 2, 0);
    run_vec("t2_e5", 1, 4'hC, 0, 0, 1, 4'hA, 3, 1);
    run_vec("t2_e6", 1, 4'h3, 1, 0, 1, 4'hA, 3, 1);
    run_vec("t2_e7", 0, 4'h0, 0, 0, 1, 4'hB, 2, 2);
    run_vec("t2_e8", 0, 4'h0, 0, 0, 1, 4'hC, 1, 3);
    run_vec("t2_e9", 0, 4'h0, 0, 0, 0, 4'h0, 0, 3);

    // Flush a full pipe together with a valid 0xF, then flush beating stall.
    do_reset();
    run_vec("t3_e1", 1, 4'h1, 0, 0, 0, 4'h0, 1, 0);
    run_vec("t3_e2", 1, 4'h2, 0, 0, 0, 4'h0, 2, 0);
    run_vec("t3_e3", 1, 4'h3, 0, 0, 1, 4'h1, 3, 1);
    run_vec("t3_e4", 1, 4'hF, 0, 1, 0, 4'h0, 0, 1);
    run_vec("t3_e5", 0, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    run_vec("t3_e6", 0, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    run_vec("t3_e7", 0, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    run_vec("t3_e8", 1, 4'h9, 0, 0, 0, 4'h0, 1, 1);
    run_vec("t3_e9", 1, 4'h5, 1, 1, 0, 4'h0, 0, 1);
    run_vec("t3_e10", 0, 4'h0, 0, 0, 0, 4'h0, 0, 1);

    // 300 continuous words: count saturates at 255.
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      va = 1'b1;
      da = 4'(k);
      tick();
      if (k == 256) check("t4_tot256", a_tot, 254);
      if (k == 257) check("t4_tot257", a_tot, 255);
      if (k == 258) check("t4_tot258", a_tot, 255);
    end
    check("t4_tot300", a_tot, 255);
    va = 1'b0;

    // Asynchronous reset between edges, then normal operation on the next edge.
    do_reset();
    run_vec("t5_e1", 1, 4'h1, 0, 0, 0, 4'h0, 1, 0);
    run_vec("t5_e2", 1, 4'h2, 0, 0, 0, 4'h0, 2, 0);
    run_vec("t5_e3", 1, 4'h3, 0, 0, 1, 4'h1, 3, 1);
    #2 reset_L = 1'b0;
    #1;
    check("t5_async_vld", a_vout, 0);
    check("t5_async_dat", a_dout, 0);
    check("t5_async_occ", a_occ, 0);
    check("t5_async_tot", a_tot, 0);
    #1 reset_L = 1'b1;
    run_vec("t5_e4", 1, 4'h4, 0, 0, 0, 4'h0, 1, 0);
    run_vec("t5_e5", 0, 4'h0, 0, 0, 0, 4'h0, 1, 0);
    run_vec("t5_e6", 0, 4'h0, 0, 0, 1, 4'h4, 1, 1);
    run_vec("t5_e7", 0, 4'h0, 0, 0, 0, 4'h0, 0, 1);

    // Alternating valid on the 16x8 instance: pattern reappears eight cycles later.
    do_reset();
    for (int c = 1; c <= 22; c++) begin
      int m;
      int eocc;
      logic ev;
      vb = (c <= 12) && (c % 2 == 1);
      db = 16'h1000 + 16'(c);
      tick();
      m  = c - 7;
      ev = (m >= 1) && (m <= 12) && (m % 2 == 1);
      check("t6_vld", b_vout, ev);
      check("t6_dat", b_dout, ev ? 32'h1000 + m : 0);
      eocc = 0;
      for (int j = c - 7; j <= c; j++) begin
        if (j >= 1 && j <= 12 && (j % 2 == 1)) eocc++;
      end
      check("t6_occ", b_occ, eocc);
    end
    check("t6_tot", b_tot, 6);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/linea_retardo.md
LINEA_RETARDO -- requirements
Module: linea_retardo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter DEPTH, default 3, giving the number of pipeline stages (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_L, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port valid_in, input, 1 bit, marking data_in as valid this cycle.
REQ-006 The block SHALL have port data_in, input, WIDTH bits, the input payload.
REQ-007 The block SHALL have port stall, input, 1 bit, which holds all stages when high.
REQ-008 The block SHALL have port flush, input, 1 bit, which invalidates all stages when high.
REQ-009 The block SHALL have port valid_out, output, 1 bit, marking data_out as valid; it is registered.
REQ-010 The block SHALL have port data_out, output, WIDTH bits, the delayed payload; it is registered.
REQ-011 The block SHALL have port ocupacion, output, clog2(DEPTH+1) bits, the count of valid stages; it is registered.
REQ-012 The block SHALL have port total_out, output, 8 bits, a saturating count of valid words emitted.

Function
REQ-013 With stall=0 and flush=0, on each edge stage 0 SHALL load {valid_in, data_in} and stage k SHALL load stage k-1.
REQ-014 A word accepted at edge n SHALL appear on valid_out/data_out after exactly DEPTH non-stalled edges; with no stalls, latency is DEPTH cycles.
REQ-015 A stage whose valid bit is 0 SHALL hold data 0; invalid input SHALL load data 0, not data_in.
REQ-016 With stall=1 and flush=0, every stage, valid_out, data_out, ocupacion and total_out SHALL hold; valid_in is ignored and that input is dropped.
REQ-017 With flush=1, all valid bits and data SHALL clear to 0 on the edge, and ocupacion SHALL become 0.
REQ-018 flush SHALL take priority over stall and valid_in; a word presented in a flush cycle is dropped.
REQ-019 ocupacion SHALL equal the number of set valid bits across all DEPTH stages after each edge.
REQ-020 ocupacion SHALL update by +1, -1 or 0 on the edge, according to the entering and leaving valid bits.
REQ-021 total_out SHALL increment on each edge where the final stage loads a valid word, and SHALL saturate at 255 without wrapping.
REQ-022 flush SHALL NOT clear total_out.
REQ-023 With DEPTH=1, the block SHALL degenerate to a single registered stage with identical rules.

Reset
REQ-024 reset_L=0 SHALL asynchronously force all stage valid bits, stage data, valid_out, data_out, ocupacion and total_out to 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight words.
REQ-026 On the first rising clk edge after reset_L rises, the block SHALL operate normally, sampling inputs on that edge.

Structure
REQ-027 A shared package linea_retardo_pkg SHALL hold the default WIDTH and DEPTH constants and the width function for ocupacion.
REQ-028 One sub-module, etapa_retardo, SHALL implement one valid+data stage with stall and flush inputs, instantiated DEPTH times via generate.
REQ-029 The ocupacion and total_out counters SHALL reside in the top module.

Verification
REQ-030 Reset, then valid_in=1 with data 1..5 on consecutive cycles at WIDTH=4, DEPTH=3 -> data_out 1..5 on cycles 3..7 with valid_out=1, and total_out=5.
REQ-031 Stream 0xA,0xB,0xC, then stall=1 for 2 cycles -> outputs and ocupacion frozen; after release 0xA emerges 3 non-stalled edges after entry.
REQ-032 Fill 3 stages (ocupacion=3), then flush together with valid_in=1, data 0xF -> next cycle ocupacion=0, valid_out=0, and 0xF never appears.
REQ-033 Stream continuously for 300 cycles -> total_out stops at 255.
REQ-034 Pulse reset_L low asynchronously between edges mid-stream -> all outputs 0 immediately, before the next clk edge.
REQ-035 Alternate valid_in 1/0 with DEPTH=8, WIDTH=16 -> valid_out pattern is reproduced 8 cycles later, and data is 0 in the bubbles.
